// File: rtl/imem_prog_loader.sv
// Byte-stream program loader: receives a framed image (16-bit count, N big-endian
// words, checksum byte), writes it to instruction memory and gates the core's reset.
module imem_prog_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    input  logic                  start,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  load_error
);

    localparam logic [2:0] S_HDR_HI = 3'd0;
    localparam logic [2:0] S_HDR_LO = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_CSUM   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;

    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

    logic [2:0]            state;
    logic [15:0]           count;
    logic [ADDR_WIDTH:0]   word_idx;
    logic [1:0]            byte_idx;
    logic [31:0]           shreg;
    logic [7:0]            acc;

    logic                  accept;
    logic [16:0]           hdr_count;
    logic [16:0]           next_word;
    logic                  loading;

    assign loading    = (state == S_HDR_HI) || (state == S_HDR_LO) ||
                        (state == S_DATA)   || (state == S_CSUM);
    assign byte_ready = reset && loading;
    assign accept     = byte_valid && byte_ready;

    // Full count as it will stand once the low header byte is latched.
    assign hdr_count  = {1'b0, count[15:8], byte_in};
    assign next_word  = 17'(word_idx) + 17'd1;

    // Status outputs decode the registered state, so they change one edge after the deciding accept.
    assign cpu_reset  = (state != S_DONE);
    assign load_done  = (state == S_DONE);
    assign load_error = (state == S_ERROR);

    // NOTE: every register here uses <= so all of them sample pre-edge values in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_HDR_HI;
            count      <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
            shreg      <= '0;
            acc        <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_HDR_HI: begin
                    if (accept) begin
                        count[15:8] <= byte_in;
                        acc         <= acc + byte_in;
                        state       <= S_HDR_LO;
                    end
                end
                S_HDR_LO: begin
                    if (accept) begin
                        count[7:0] <= byte_in;
                        acc        <= acc + byte_in;
                        if (hdr_count > MAX_WORDS)
                            state <= S_ERROR;
                        else if (hdr_count == 17'd0)
                            state <= S_CSUM;
                        else
                            state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        shreg    <= {shreg[23:0], byte_in};
                        acc      <= acc + byte_in;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= word_idx[ADDR_WIDTH-1:0];
                            imem_wdata <= {shreg[23:0], byte_in};
                            word_idx   <= word_idx + 1'b1;
                            if (next_word == {1'b0, count})
                                state <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (accept)
                        state <= (byte_in == acc) ? S_DONE : S_ERROR;
                end
                S_DONE, S_ERROR: begin
                    if (start) begin
                        state    <= S_HDR_HI;
                        count    <= '0;
                        word_idx <= '0;
                        byte_idx <= '0;
                        shreg    <= '0;
                        acc      <= '0;
                    end
                end
                default: state <= S_HDR_HI;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_prog_loader.sv
// Directed bench for imem_prog_loader: frames are streamed byte by byte and the
// captured memory writes and status outputs are compared with hand-computed values.
module tb_imem_prog_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        start;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        load_done;
    logic        load_error;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  frame_q[$];
    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];

    imem_prog_loader #(.ADDR_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .start      (start),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .load_error (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every write strobe half a cycle after the edge that raised it.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int waited;
        repeat (gap) begin
            @(negedge clk);
            byte_valid = 1'b0;
        end
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        waited     = 0;
        while (!byte_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!byte_ready)
            check("ready_timeout", 32'(byte_ready), 32'd1);
        else
            @(posedge clk);
    endtask

    task automatic send_frame(input int gap_max);
        foreach (frame_q[i])
            send(frame_q[i], (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic build_basic(input logic [7:0] csum);
        frame_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
                    8'hDE, 8'hAD, 8'hBE, 8'hEF, csum};
    endtask

    task automatic clear_writes();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic check_basic_writes(input string tag);
        check({tag, "_wr_count"}, 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check({tag, "_addr0"}, 32'(wr_addr[0]), 32'h0);
            check({tag, "_data0"}, wr_data[0], 32'h12345678);
            check({tag, "_addr1"}, 32'(wr_addr[1]), 32'h1);
            check({tag, "_data1"}, wr_data[1], 32'hDEADBEEF);
        end
    endtask

    task automatic check_status(input string tag, input logic done, input logic err, input logic crst);
        check({tag, "_done"},      32'(load_done),  32'(done));
        check({tag, "_error"},     32'(load_error), 32'(err));
        check({tag, "_cpu_reset"}, 32'(cpu_reset),  32'(crst));
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [7:0]  b;
        logic [7:0]  sum;
        logic [31:0] exp_last;

        reset      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        start      = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_ready", 32'(byte_ready), 32'd0);
        check("rst_we",    32'(imem_we),    32'd0);
        check("rst_addr",  32'(imem_addr),  32'd0);
        check("rst_wdata", imem_wdata,      32'd0);
        check_status("rst", 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(byte_ready), 32'd1);

        // Basic load, continuous stream.
        clear_writes();
        build_basic(8'h4E);
        send_frame(0);
        check_basic_writes("basic");
        check_status("basic", 1'b1, 1'b0, 1'b0);
        check("basic_ready", 32'(byte_ready), 32'd0);

        // Start in DONE returns to loading; same frame with a bad checksum.
        pulse_start();
        check_status("restart", 1'b0, 1'b0, 1'b1);
        check("restart_ready", 32'(byte_ready), 32'd1);
        clear_writes();
        build_basic(8'h4F);
        send_frame(0);
        check_basic_writes("badcsum");
        check_status("badcsum", 1'b0, 1'b1, 1'b1);
        check("badcsum_ready", 32'(byte_ready), 32'd0);

        // Empty image: done one cycle after the checksum byte.
        pulse_start();
        check_status("err_restart", 1'b0, 1'b0, 1'b1);
        clear_writes();
        frame_q = '{8'h00, 8'h00, 8'h00};
        send_frame(0);
        check("empty_wr_count", 32'(wr_addr.size()), 32'd0);
        check_status("empty", 1'b1, 1'b0, 1'b0);

        // Oversized count 0x0101: error right after the header; later bytes ignored.
        pulse_start();
        clear_writes();
        frame_q = '{8'h01, 8'h01};
        send_frame(0);
        check_status("over", 1'b0, 1'b1, 1'b1);
        check("over_ready", 32'(byte_ready), 32'd0);
        byte_in    = 8'h55;
        byte_valid = 1'b1;
        repeat (3) @(negedge clk);
        byte_valid = 1'b0;
        check("over_wr_count", 32'(wr_addr.size()), 32'd0);
        check("over_still_err", 32'(load_error), 32'd1);

        // Maximum image: 256 words, last write lands at 0xFF.
        pulse_start();
        clear_writes();
        frame_q = '{8'h01, 8'h00};
        sum = 8'h01;
        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < 4; j++) begin
                b = 8'(i * 7 + j * 13);
                frame_q.push_back(b);
                sum = sum + b;
            end
        end
        frame_q.push_back(sum);
        exp_last = {8'(255 * 7), 8'(255 * 7 + 13), 8'(255 * 7 + 26), 8'(255 * 7 + 39)};
        send_frame(0);
        check("max_wr_count", 32'(wr_addr.size()), 32'd256);
        if (wr_addr.size() == 256) begin
            check("max_first_addr", 32'(wr_addr[0]), 32'h00);
            check("max_first_data", wr_data[0], 32'h000D1A27);
            check("max_last_addr", 32'(wr_addr[255]), 32'hFF);
            check("max_last_data", wr_data[255], exp_last);
        end
        check_status("max", 1'b1, 1'b0, 1'b0);

        // Basic frame with random idle gaps between bytes.
        pulse_start();
        clear_writes();
        build_basic(8'h4E);
        send_frame(3);
        check_basic_writes("gaps");
        check_status("gaps", 1'b1, 1'b0, 1'b0);

        // Reset after three data bytes discards the partial word.
        pulse_start();
        clear_writes();
        frame_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56};
        send_frame(0);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", 32'(byte_ready), 32'd0);
        check("mid_rst_we",    32'(imem_we),    32'd0);
        check("mid_rst_addr",  32'(imem_addr),  32'd0);
        check("mid_rst_wdata", imem_wdata,      32'd0);
        check_status("mid_rst", 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_wr_count", 32'(wr_addr.size()), 32'd0);
        build_basic(8'h4E);
        send_frame(0);
        check_basic_writes("after_rst");
        check_status("after_rst", 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
